// File: rtl/acc_pkg.sv
`default_nettype none
// ==== acc_pkg: shared state encoding and width defaults for the product accumulator | rev 1.0 ====
package acc_pkg;

  localparam int ACC_W_DEF   = 72;
  localparam int COUNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/product_accumulator_if.sv
`default_nettype none
// ==== product_accumulator_if: product input stream and term result handshake | rev 1.0 ====
interface product_accumulator_if #(
  parameter int N       = 32,
  parameter int ACC_W   = 72,
  parameter int COUNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*N-1:0]       in_product;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_sum;
  logic [COUNT_W-1:0]   out_count;
  logic                 out_ovf;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/acc_sat_adder.sv
`default_nettype none
// ==== acc_sat_adder: signed ACC_W adder with overflow flag; clamps when ACC_SATURATE_EN is defined | rev 1.0 ====
module acc_sat_adder #(
  parameter int ACC_W = 72
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic [ACC_W-1:0] raw;

  assign raw = a + b;
  // Overflow only possible when both addends share a sign and the result flips it
  assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

`ifdef ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  assign sum = ovf ? (a[ACC_W-1] ? MIN_NEG : MAX_POS) : raw;
`else
  assign sum = raw;
`endif

endmodule
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ==== product_accumulator: sums a stream of signed products into one term per "last" beat | rev 1.0 ====
// ==== Build option: ACC_SATURATE_EN selects clamping instead of wrap-around on overflow.          ====
module product_accumulator
  import acc_pkg::*;
#(
  parameter int N       = 32,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  product_accumulator_if.slave bus
);
  localparam int PROD_W = 2 * N;

  state_t               state, state_nxt;
  logic [ACC_W-1:0]     acc;
  logic [COUNT_W-1:0]   count;
  logic                 ovf;
  logic [ACC_W-1:0]     out_sum_q;
  logic [COUNT_W-1:0]   out_count_q;
  logic                 out_ovf_q;

  logic signed [PROD_W-1:0] product;
  logic [ACC_W-1:0]     acc_base;
  logic [ACC_W-1:0]     product_ext;
  logic [ACC_W-1:0]     acc_nxt;
  logic                 add_ovf;
  logic [COUNT_W-1:0]   count_base;
  logic [COUNT_W-1:0]   count_nxt;
  logic                 ovf_nxt;
  logic                 accept;
  logic                 release_term;

  assign product     = bus.in_product;
  assign product_ext = ACC_W'(product);

  // A fresh term starts from zero regardless of what the registers hold
  assign acc_base   = (state == IDLE) ? '0 : acc;
  assign count_base = (state == IDLE) ? '0 : count;
  assign count_nxt  = (&count_base) ? count_base : count_base + COUNT_W'(1);
  assign ovf_nxt    = ((state == IDLE) ? 1'b0 : ovf) | add_ovf;

  assign accept       = bus.in_valid && (state != DONE);
  assign release_term = (state == DONE) && bus.out_ready;

  acc_sat_adder #(
    .ACC_W (ACC_W)
  ) u_adder (
    .a   (acc_base),
    .b   (product_ext),
    .sum (acc_nxt),
    .ovf (add_ovf)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) state_nxt = bus.in_last ? DONE : ACCUM;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc   <= acc_nxt;
        count <= count_nxt;
        ovf   <= ovf_nxt;
        if (bus.in_last) begin
          out_sum_q   <= acc_nxt;
          out_count_q <= count_nxt;
          out_ovf_q   <= ovf_nxt;
        end
      end else if (release_term) begin
        acc   <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ==== tb_product_accumulator: table vectors, corner sequences and random terms vs. an arithmetic model | rev 1.0 ====
module tb_product_accumulator;
  localparam int N       = 4;
  localparam int ACC_W   = 8;
  localparam int COUNT_W = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] beats[$];

  always #5 clk = ~clk;

  product_accumulator_if #(.N(N), .ACC_W(ACC_W), .COUNT_W(COUNT_W)) bus ();

  product_accumulator #(.N(N), .ACC_W(ACC_W), .COUNT_W(COUNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [3:0]  n;
    logic [79:0] prod;   // beat 0 in the top byte
    logic [7:0]  sum;
    logic [2:0]  cnt;
    logic        ovf;
    logic [2:0]  stall;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic with range checks on each addition
  task automatic model(output int s, output int c, output int o);
    int acc;
    int t;
    acc = 0;
    o   = 0;
    foreach (beats[i]) begin
      t = acc + int'($signed(beats[i]));
      if (t > 127 || t < -128) begin
        o = 1;
`ifdef ACC_SATURATE_EN
        acc = (t > 127) ? 127 : -128;
`else
        acc = (t > 127) ? t - 256 : t + 256;
`endif
      end else begin
        acc = t;
      end
    end
    s = acc;
    c = (beats.size() > 7) ? 7 : beats.size();
  endtask

  task automatic send_term(input bit gaps);
    for (int i = 0; i < beats.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid   = 1'b0;
          bus.in_product = 8'($urandom);
          bus.in_last    = 1'($urandom);
          tick();
        end
      end
      chk("in_ready_beat", int'(bus.in_ready), 1);
      bus.in_valid   = 1'b1;
      bus.in_product = beats[i];
      bus.in_last    = (i == beats.size() - 1);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_result(input string nm, input int es, input int ec, input int eo,
                              input int stall);
    chk({nm, "_valid"}, int'(bus.out_valid), 1);
    chk({nm, "_sum"},   int'($signed(bus.out_sum)), es);
    chk({nm, "_count"}, int'(bus.out_count), ec);
    chk({nm, "_ovf"},   int'(bus.out_ovf), eo);
    for (int k = 0; k < stall; k++) begin
      tick();
      chk({nm, "_hold_valid"}, int'(bus.out_valid), 1);
      chk({nm, "_hold_sum"},   int'($signed(bus.out_sum)), es);
      chk({nm, "_hold_ready"}, int'(bus.in_ready), 0);
    end
    // Offer a beat during the handshake cycle; it must not be taken
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_product = 8'h11;
    bus.in_last    = 1'b1;
    chk({nm, "_hs_ready"}, int'(bus.in_ready), 0);
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    chk({nm, "_rel_valid"}, int'(bus.out_valid), 0);
    chk({nm, "_rel_ready"}, int'(bus.in_ready), 1);
    chk({nm, "_rel_sum"},   int'($signed(bus.out_sum)), es);
  endtask

  initial begin
    int s, c, o;
    vec_t v;

    vecs[0] = '{4'd3, {8'h0C, 8'hFB, 8'h07, 56'd0}, 8'd14, 3'd3, 1'b0, 3'd5};
`ifdef ACC_SATURATE_EN
    vecs[1] = '{4'd2, {8'h64, 8'h64, 64'd0}, 8'h7F, 3'd2, 1'b1, 3'd0};
    vecs[4] = '{4'd2, {8'h9C, 8'h9C, 64'd0}, 8'h80, 3'd2, 1'b1, 3'd1};
    vecs[5] = '{4'd3, {8'h64, 8'h64, 8'h9C, 56'd0}, 8'h1B, 3'd3, 1'b1, 3'd0};
`else
    vecs[1] = '{4'd2, {8'h64, 8'h64, 64'd0}, 8'hC8, 3'd2, 1'b1, 3'd0};
    vecs[4] = '{4'd2, {8'h9C, 8'h9C, 64'd0}, 8'h38, 3'd2, 1'b1, 3'd1};
    vecs[5] = '{4'd3, {8'h64, 8'h64, 8'h9C, 56'd0}, 8'h64, 3'd3, 1'b1, 3'd0};
`endif
    vecs[2] = '{4'd1, {8'hC0, 72'd0}, 8'hC0, 3'd1, 1'b0, 3'd2};
    vecs[3] = '{4'd9, {{9{8'h01}}, 8'd0}, 8'd9, 3'd7, 1'b0, 3'd0};

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_sum",   int'(bus.out_sum), 0);
    chk("rst_out_count", int'(bus.out_count), 0);
    chk("rst_out_ovf",   int'(bus.out_ovf), 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      v = vecs[i];
      beats.delete();
      for (int b = 0; b < int'(v.n); b++) beats.push_back(v.prod[79 - 8*b -: 8]);
      send_term(1'b0);
      check_result($sformatf("vec%0d", i), int'($signed(v.sum)), int'(v.cnt), int'(v.ovf),
                   int'(v.stall));
    end

    // Reset in the middle of a term discards the partial sum
    bus.in_valid = 1'b1;
    bus.in_product = 8'd20;
    tick();
    bus.in_product = 8'd30;
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_valid", int'(bus.out_valid), 0);
    chk("abort_sum",   int'(bus.out_sum), 0);
    chk("abort_ready", int'(bus.in_ready), 1);
    beats.delete();
    beats.push_back(8'd3);
    send_term(1'b0);
    check_result("abort_next", 3, 1, 0, 0);

    // Random terms with idle gaps and random consumer stalls
    for (int t = 0; t < 40; t++) begin
      beats.delete();
      repeat ($urandom_range(1, 10)) beats.push_back(8'($urandom));
      model(s, c, o);
      send_term(1'b1);
      check_result($sformatf("rnd%0d", t), s, c, o, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
